fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, small FIFO of fetched words toward decode.
// Latency: rvalid in cycle N gives o_if_valid in N+1; a request goes out only when the FIFO has room.
// Backpressure: i_id_ready stalls the FIFO head; a full FIFO withholds requests and holds the PC.
module fetch_stage #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    input  logic        i_flush,
    output logic        o_pc_en,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic        o_if_misalign,
    input  logic        i_id_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state;
    logic             drop;
    logic [31:0]      inf_pc;
    logic [31:0]      inf_pc4;
    logic             inf_mis;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_pc4   [FIFO_DEPTH];
    logic             fifo_mis   [FIFO_DEPTH];

    logic             can_req;
    logic             accept;
    logic             push;
    logic             pop;

    // Reset gates the combinational outputs so nothing leaks out while resetn is low.
    assign can_req     = (state == S_REQ) && (count < CNT_W'(FIFO_DEPTH)) && !i_flush;
    assign o_imem_req  = resetn & can_req;
    assign accept      = o_imem_req & i_imem_ready;
    assign o_pc_en     = resetn & (accept | i_flush);
    assign o_imem_addr = {i_pc[31:2], 2'b00};

    assign push = (state == S_WAIT) & i_imem_rvalid & ~drop & ~i_flush;
    assign pop  = o_if_valid & i_id_ready;

    assign o_if_valid    = (count != '0);
    assign o_if_instr    = fifo_instr[rd_ptr];
    assign o_if_pc       = fifo_pc[rd_ptr];
    assign o_if_pc4      = fifo_pc4[rd_ptr];
    assign o_if_misalign = fifo_mis[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_REQ;
            drop    <= 1'b0;
            inf_pc  <= '0;
            inf_pc4 <= '0;
            inf_mis <= 1'b0;
        end else if (state == S_REQ) begin
            if (accept) begin
                state   <= S_WAIT;
                inf_pc  <= i_pc;
                inf_pc4 <= i_pc4;
                inf_mis <= |i_pc[1:0];
            end
        end else if (i_imem_rvalid) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end else if (i_flush) begin
            // Redirect while a response is still in flight: it is discarded on arrival.
            drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
                fifo_pc4[i]   <= '0;
                fifo_mis[i]   <= 1'b0;
            end
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= i_imem_rdata;
                fifo_pc[wr_ptr]    <= inf_pc;
                fifo_pc4[wr_ptr]   <= inf_pc4;
                fifo_mis[wr_ptr]   <= inf_mis;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random traffic against a queue-based model.
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        resetn;
    logic [31:0] i_pc;
    logic [31:0] i_pc4;
    logic        i_flush;
    logic        o_pc_en;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc4;
    logic        o_if_misalign;
    logic        i_id_ready;

    fetch_stage #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_pc          (i_pc),
        .i_pc4         (i_pc4),
        .i_flush       (i_flush),
        .o_pc_en       (o_pc_en),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_valid    (o_if_valid),
        .o_if_instr    (o_if_instr),
        .o_if_pc       (o_if_pc),
        .o_if_pc4      (o_if_pc4),
        .o_if_misalign (o_if_misalign),
        .i_id_ready    (i_id_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
    } ent_t;

    // Model: decoded-instruction queue plus "a request is outstanding" and "its reply is stale".
    ent_t m_q[$];
    logic m_wait;
    logic m_drop;
    ent_t m_inf;
    logic last_acc;

    int total;
    int bad;

    logic       mem_pend;
    int         mem_dly;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wait   = 1'b0;
        m_drop   = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic cycle();
        logic e_req;
        logic e_pen;
        logic acc;
        ent_t h;
        @(negedge clk);
        e_req = !m_wait && (m_q.size() < DEPTH) && !i_flush;
        e_pen = (e_req && i_imem_ready) || i_flush;
        chk("imem_req", o_imem_req, e_req);
        chk("imem_addr", o_imem_addr, i_pc & 32'hFFFF_FFFC);
        chk("pc_en", o_pc_en, e_pen);
        chk("if_valid", o_if_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("if_instr", o_if_instr, h.instr);
            chk("if_pc", o_if_pc, h.pc);
            chk("if_pc4", o_if_pc4, h.pc4);
            chk("if_misalign", o_if_misalign, h.mis);
        end
        acc      = e_req && i_imem_ready;
        last_acc = acc;
        if (i_flush) begin
            m_q.delete();
        end else begin
            if (m_q.size() != 0 && i_id_ready) void'(m_q.pop_front());
            if (m_wait && i_imem_rvalid && !m_drop)
                m_q.push_back('{i_imem_rdata, m_inf.pc, m_inf.pc4, m_inf.mis});
        end
        if (!m_wait) begin
            if (acc) begin
                m_wait = 1'b1;
                m_inf  = '{32'h0, i_pc, i_pc4, (i_pc[1:0] != 2'b00)};
            end
        end else if (i_imem_rvalid) begin
            m_wait = 1'b0;
            m_drop = 1'b0;
        end else if (i_flush) begin
            m_drop = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_imem_req", o_imem_req, 1'b0);
        chk("rst_pc_en", o_pc_en, 1'b0);
        chk("rst_if_valid", o_if_valid, 1'b0);
        chk("rst_if_instr", o_if_instr, 32'h0);
        chk("rst_if_pc", o_if_pc, 32'h0);
        chk("rst_if_pc4", o_if_pc4, 32'h0);
        chk("rst_if_misalign", o_if_misalign, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_pc = 32'h0; i_pc4 = 32'h4; i_flush = 1'b0;
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        i_id_ready = 1'b0;
        mem_pend = 1'b0; mem_dly = 0;
        model_reset();
        do_reset();

        // Basic fetch at PC 0 with a one-cycle memory reply.
        i_pc = 32'h0; i_pc4 = 32'h4; i_imem_ready = 1'b1; i_id_ready = 1'b1;
        #1;
        chk("d34_req", o_imem_req, 1'b1);
        chk("d34_addr", o_imem_addr, 32'h0);
        chk("d34_pc_en", o_pc_en, 1'b1);
        cycle();
        i_pc = 32'h4; i_pc4 = 32'h8; i_imem_ready = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0013;
        #1;
        chk("d34_pc_en_wait", o_pc_en, 1'b0);
        cycle();
        i_imem_rvalid = 1'b0;
        #1;
        chk("d34_valid", o_if_valid, 1'b1);
        chk("d34_instr", o_if_instr, 32'h0000_0013);
        chk("d34_pc", o_if_pc, 32'h0);
        chk("d34_pc4", o_if_pc4, 32'h4);
        cycle();
        chk("d34_popped", o_if_valid, 1'b0);

        // Decode stalled: two back-to-back fetches fill the FIFO, then requests stop.
        i_id_ready = 1'b0; i_imem_ready = 1'b1; i_pc = 32'h0; i_pc4 = 32'h4;
        cycle();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hAAAA_0001; i_pc = 32'h4; i_pc4 = 32'h8;
        cycle();
        i_imem_rvalid = 1'b0;
        cycle();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hAAAA_0002; i_pc = 32'h8; i_pc4 = 32'hC;
        cycle();
        i_imem_rvalid = 1'b0;
        #1;
        chk("d35_req_full", o_imem_req, 1'b0);
        chk("d35_pc_en_full", o_pc_en, 1'b0);
        chk("d35_head_pc", o_if_pc, 32'h0);
        cycle();
        cycle();
        chk("d35_pc_en_hold", o_pc_en, 1'b0);
        i_id_ready = 1'b1;
        cycle();
        chk("d35_req_after_pop", o_imem_req, 1'b1);
        chk("d35_head_pc2", o_if_pc, 32'h4);
        i_id_ready = 1'b0;
        cycle();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hAAAA_0003;
        cycle();
        i_imem_rvalid = 1'b0;

        // Flush with two entries buffered and decode ready.
        i_flush = 1'b1; i_id_ready = 1'b1; i_imem_ready = 1'b1;
        #1;
        chk("d37_valid_before", o_if_valid, 1'b1);
        chk("d37_req_flush", o_imem_req, 1'b0);
        chk("d37_pc_en_flush", o_pc_en, 1'b1);
        cycle();
        i_flush = 1'b0; i_imem_ready = 1'b0;
        #1;
        chk("d37_valid_after", o_if_valid, 1'b0);
        cycle();
        cycle();
        chk("d37_still_empty", o_if_valid, 1'b0);

        // Flush while a request at 0x8 is in flight: its reply is dropped.
        i_id_ready = 1'b0; i_pc = 32'h8; i_pc4 = 32'hC; i_imem_ready = 1'b1;
        cycle();
        i_flush = 1'b1; i_pc = 32'h100; i_pc4 = 32'h104; i_imem_ready = 1'b0;
        cycle();
        i_flush = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
        cycle();
        i_imem_rvalid = 1'b0; i_imem_ready = 1'b1;
        #1;
        chk("d36_dropped", o_if_valid, 1'b0);
        chk("d36_req", o_imem_req, 1'b1);
        chk("d36_addr", o_imem_addr, 32'h100);
        cycle();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1111_1111; i_imem_ready = 1'b0;
        cycle();
        i_imem_rvalid = 1'b0;
        #1;
        chk("d36_new_pc", o_if_pc, 32'h100);
        chk("d36_new_instr", o_if_instr, 32'h1111_1111);
        i_id_ready = 1'b1;
        cycle();
        i_id_ready = 1'b0;

        // Misaligned PC.
        i_pc = 32'h6; i_pc4 = 32'hA; i_imem_ready = 1'b1;
        #1;
        chk("d38_addr", o_imem_addr, 32'h4);
        cycle();
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_2222;
        cycle();
        i_imem_rvalid = 1'b0;
        #1;
        chk("d38_mis", o_if_misalign, 1'b1);
        chk("d38_pc", o_if_pc, 32'h6);
        i_id_ready = 1'b1;
        cycle();
        i_id_ready = 1'b0;

        // Reset while waiting; the late reply must be ignored.
        i_pc = 32'h20; i_pc4 = 32'h24; i_imem_ready = 1'b1;
        cycle();
        i_imem_ready = 1'b0;
        do_reset();
        i_pc = 32'h40; i_pc4 = 32'h44; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h3333_3333;
        #1;
        chk("d39_req", o_imem_req, 1'b1);
        cycle();
        i_imem_rvalid = 1'b0;
        #1;
        chk("d39_no_push", o_if_valid, 1'b0);
        chk("d39_addr", o_imem_addr, 32'h40);
        i_imem_ready = 1'b1;
        cycle();
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h4444_4444;
        cycle();
        i_imem_rvalid = 1'b0;
        cycle();

        // Random traffic: variable memory latency, stray rvalids, flushes, decode stalls.
        for (int n = 0; n < 3000; n++) begin
            i_flush      = ($urandom_range(0, 9) == 0);
            i_id_ready   = $urandom_range(0, 1);
            i_imem_ready = ($urandom_range(0, 3) != 0);
            i_pc         = $urandom;
            if ($urandom_range(0, 3) != 0) i_pc[1:0] = 2'b00;
            i_pc4        = i_pc + 32'd4;
            i_imem_rdata = $urandom;
            if (mem_pend && mem_dly == 0)
                i_imem_rvalid = 1'b1;
            else
                i_imem_rvalid = !mem_pend && !m_wait && ($urandom_range(0, 19) == 0);
            cycle();
            if (mem_pend) begin
                if (mem_dly == 0) mem_pend = 1'b0;
                else mem_dly--;
            end
            if (last_acc) begin
                mem_pend = 1'b1;
                mem_dly  = $urandom_range(0, 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
